// File: rtl/tx_datapath_ctrl.sv
// tx_datapath_ctrl
// Control and output stage of the N-channel transmit pulse-shaping path. It
// sits between the per-channel fir_filter instances and the DAC pins.
//
// Functions:
//   * Decodes the SPI coefficient bus into per-channel write/read strobes and
//     a channel-local address. Read-back data is registered, 1 cycle latency.
//   * Tracks filter fill/drain latency. The result is a data-valid window
//     (FSM IDLE -> FILL -> RUN).
//   * Reduces the wide FIR outputs to DAC width with selectable rounding and
//     saturation. Samples are forced to zero outside the valid window.
//
// Ports:
//   clk, rst_n_sync_wire      clock, asynchronous active-low reset
//   new_symbol                symbol strobe from the upsampler source
//   flush                     synchronous abort to IDLE, clears sat_flag
//   msg_in, coeff_rw          SPI message active, 1=write / 0=read
//   coeff_addr                global coefficient address
//   coeff_write_ch/read_ch    per-channel coefficient strobes
//   coeff_local_addr          address inside the hit channel window, else 0
//   coeff_rdata_ch            per-channel read data, channel k at [k*COEFF_W +: COEFF_W]
//   coeff_read_out            registered read-back data
//   round_mode                0/3 truncate, 1 round toward zero, 2 round half up
//   filter_in                 signed FIR outputs, flattened like coeff_rdata_ch
//   data_out                  signed DAC samples, flattened
//   data_valid                valid window (state == RUN)
//   data_out_valid            data_valid delayed one cycle, aligned with data_out
//   sat_flag                  sticky per-channel saturation flags
//
// Handshake: there is no back-pressure. new_symbol is a single-cycle strobe.
// data_out_valid qualifies data_out in the same cycle.
module tx_datapath_ctrl #(
    parameter int NUM_CH  = 2,
    parameter int IN_W    = 12,
    parameter int OUT_W   = 10,
    parameter int COEFF_W = 8,
    parameter int ADDR_W  = 10,
    parameter int TAPS    = 71,
    parameter int BASE0   = 128,
    parameter int STRIDE  = 128,
    parameter int LATENCY = 144,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n_sync_wire,
    input  logic                      new_symbol,
    input  logic                      flush,
    input  logic                      msg_in,
    input  logic                      coeff_rw,
    input  logic [ADDR_W-1:0]         coeff_addr,
    output logic [NUM_CH-1:0]         coeff_write_ch,
    output logic [NUM_CH-1:0]         coeff_read_ch,
    output logic [ADDR_W-1:0]         coeff_local_addr,
    input  logic [NUM_CH*COEFF_W-1:0] coeff_rdata_ch,
    output logic [COEFF_W-1:0]        coeff_read_out,
    input  logic [1:0]                round_mode,
    input  logic [NUM_CH*IN_W-1:0]    filter_in,
    output logic [NUM_CH*OUT_W-1:0]   data_out,
    output logic                      data_valid,
    output logic                      data_out_valid,
    output logic [NUM_CH-1:0]         sat_flag
);

    localparam int SHIFT = IN_W - OUT_W;
    localparam int HALF  = 2 ** (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   age_q, age_d, age_inc;
    logic [COEFF_W-1:0] rd_sel;
    logic [NUM_CH*OUT_W-1:0] res_all;
    logic [NUM_CH-1:0]       clip_all;

    // Coefficient address decode. The channel windows never overlap, so at
    // most one channel drives the local address.
    always_comb begin
        coeff_write_ch   = '0;
        coeff_read_ch    = '0;
        coeff_local_addr = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(coeff_addr) >= BASE0 + k * STRIDE &&
                int'(coeff_addr) <  BASE0 + k * STRIDE + TAPS) begin
                coeff_write_ch[k] = msg_in & coeff_rw;
                coeff_read_ch[k]  = msg_in & ~coeff_rw;
                coeff_local_addr  = ADDR_W'(int'(coeff_addr) - (BASE0 + k * STRIDE));
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (coeff_read_ch[k]) rd_sel = coeff_rdata_ch[k*COEFF_W +: COEFF_W];
        end
    end

    // Age counter: the number of cycles since the last new_symbol.
    // age_inc is the age value in the current cycle. The RUN exit test uses
    // it so that the window closes exactly LATENCY cycles after the last
    // symbol. It also uses >= so that a window shorter than the fill time
    // still closes after one valid cycle.
    assign age_inc = (age_q == CNT_W'(LATENCY)) ? age_q : age_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        age_d   = new_symbol ? '0 : age_inc;
        if (flush) begin
            state_d = IDLE;
            fill_d  = '0;
            age_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (new_symbol) begin
                        state_d = FILL;
                        fill_d  = CNT_W'(1);
                    end
                end
                FILL: begin
                    fill_d = fill_q + CNT_W'(1);
                    if (fill_q == CNT_W'(LATENCY - 1)) begin
                        state_d = RUN;
                        fill_d  = '0;
                    end
                end
                RUN: begin
                    if (!new_symbol && age_inc >= CNT_W'(LATENCY - 1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync_wire) begin
        if (!rst_n_sync_wire) begin
            state_q <= IDLE;
            fill_q  <= '0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            age_q   <= age_d;
        end
    end

    assign data_valid = (state_q == RUN);

    // Per-channel rounding and clamp. The sum is formed in IN_W+1 bits, so
    // rounding the most positive input up cannot wrap before the clamp.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [IN_W-1:0] x;
        logic signed [IN_W:0]   xe;
        logic signed [IN_W:0]   sh;
        logic [OUT_W-1:0]       q;
        logic                   clip;

        assign x  = filter_in[k*IN_W +: IN_W];
        assign xe = {x[IN_W-1], x};

        always_comb begin
            sh = xe >>> SHIFT;
            case (round_mode)
                2'd1: begin
                    // floor plus one for negative values with dropped bits == toward zero
                    if (x[IN_W-1] && (x[SHIFT-1:0] != '0)) sh = (xe >>> SHIFT) + (IN_W+1)'(1);
                end
                2'd2:    sh = (xe + (IN_W+1)'(HALF)) >>> SHIFT;
                default: sh = xe >>> SHIFT;
            endcase
            clip = 1'b0;
            q    = sh[OUT_W-1:0];
            if (sh > MAXV) begin
                q    = MAXV[OUT_W-1:0];
                clip = 1'b1;
            end else if (sh < MINV) begin
                q    = MINV[OUT_W-1:0];
                clip = 1'b1;
            end
        end

        assign res_all[k*OUT_W +: OUT_W] = q;
        assign clip_all[k]               = clip;
    end

    always_ff @(posedge clk or negedge rst_n_sync_wire) begin
        if (!rst_n_sync_wire) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            sat_flag       <= '0;
            coeff_read_out <= '0;
        end else begin
            data_out       <= data_valid ? res_all : '0;
            data_out_valid <= data_valid;
            coeff_read_out <= rd_sel;
            if (flush) sat_flag <= '0;
            else if (data_valid) sat_flag <= sat_flag | clip_all;
        end
    end

endmodule

// File: doc/tx_datapath_ctrl.md
Name: tx_datapath_ctrl

Overview:
Parametrised control and output stage for the N-channel transmit pulse-shaping path.
- Decodes the SPI coefficient bus into per-channel FIR coefficient strobes and local addresses, with a registered read-back mux.
- Tracks filter fill and drain latency to generate a data-valid window.
- Converts wide FIR outputs to DAC width using selectable rounding and saturation, flushed to zero outside the valid window.
- Sits between the per-channel fir_filter instances and the DAC pins.

Parameters:
NUM_CH, 2, number of filter channels (I, Q, ...)
IN_W, 12, signed FIR output width
OUT_W, 10, signed DAC output width (must be < IN_W)
COEFF_W, 8, coefficient data width
ADDR_W, 10, global coefficient address width
TAPS, 71, coefficients per channel
BASE0, 128, global base address of channel 0
STRIDE, 128, address stride between channel windows (must be >= TAPS)
LATENCY, 144, filter fill/drain cycles (must be >= 2)
CNT_W, 8, counter width (must satisfy 2^CNT_W > LATENCY)

Ports:
clk  in  1  clock
rst_n_sync_wire  in  1  asynchronous active-low reset
new_symbol  in  1  symbol strobe from the upsampler source
flush  in  1  synchronous abort: return to IDLE, clear sat_flag
msg_in  in  1  SPI message active
coeff_rw  in  1  1=write, 0=read
coeff_addr  in  ADDR_W  global coefficient address
coeff_write_ch  out  NUM_CH  per-channel write strobe
coeff_read_ch  out  NUM_CH  per-channel read strobe
coeff_local_addr  out  ADDR_W  address within the hit channel, 0 if no hit
coeff_rdata_ch  in  NUM_CH*COEFF_W  per-channel read data, channel k at bits [k*COEFF_W +: COEFF_W]
coeff_read_out  out  COEFF_W  registered read-back data
round_mode  in  2  0=truncate, 1=round toward zero, 2=round half up, 3=truncate
filter_in  in  NUM_CH*IN_W  signed FIR outputs, flattened like coeff_rdata_ch
data_out  out  NUM_CH*OUT_W  signed DAC samples
data_valid  out  1  FSM valid window
data_out_valid  out  1  data_valid delayed 1 cycle, aligned to data_out
sat_flag  out  NUM_CH  sticky per-channel saturation flag

Behaviour:
Reset values: all registered outputs 0; state IDLE; counters 0.

Address decode (combinational):
- hit_k = coeff_addr in [BASE0+k*STRIDE, BASE0+k*STRIDE+TAPS-1]; at most one channel hits.
- coeff_write_ch[k] = msg_in & coeff_rw & hit_k.
- coeff_read_ch[k] = msg_in & ~coeff_rw & hit_k.
- coeff_local_addr = coeff_addr - base_k on a hit, else 0.
- Addresses outside every window produce no strobe.

Read-back:
- coeff_read_out <= coeff_rdata_ch[k] if any coeff_read_ch[k] is set, else 0.
- Latency 1 cycle.

Age counter:
- age clears to 0 on new_symbol.
- Otherwise it increments, saturating at LATENCY.

FSM states IDLE, FILL, RUN:
- IDLE: data_valid=0. On new_symbol -> FILL with fill counter = 1.
- FILL: fill counter increments each cycle; new_symbol does not restart it. When fill counter == LATENCY-1 -> RUN. data_valid rises exactly LATENCY cycles after the first new_symbol cycle.
- RUN: data_valid=1. When age == LATENCY-1 and new_symbol=0 -> IDLE. data_valid falls LATENCY cycles after the last new_symbol.
- flush has priority over all transitions: next cycle is IDLE, counters 0, data_valid 0.
- new_symbol in the same cycle as flush is ignored.

Output stage (1 cycle, per channel):
- SHIFT = IN_W - OUT_W.
- Mode 0/3: arithmetic shift right by SHIFT (floor).
- Mode 1: floor, plus 1 if x<0 and the discarded bits are nonzero.
- Mode 2: (x + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits.
- Clamp the result to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Any clamp while data_valid=1 sets sat_flag[k]; it stays set until flush or reset.
- data_out[k] <= data_valid ? clamped result : 0.
- data_out_valid <= data_valid.
- round_mode is sampled every cycle; a change applies to the next registered sample.

Test Plan:
- Coefficient decode, defaults: msg_in=1, coeff_rw=1, addr=130 -> coeff_write_ch=01, local_addr=2. addr=199 -> strobes 00, local_addr=0. Read addr=260 with ch1 rdata=0x5A -> coeff_read_out=0x5A one cycle later, then 0 once msg_in=0.
- Valid window: new_symbol at cycle 0 and every 4 cycles to cycle 400 -> data_valid rises at cycle 144 and falls at cycle 544; data_out_valid follows each edge one cycle later.
- Rounding, IN_W=12, OUT_W=10:
  - x=-5 -> mode0 -2, mode1 -1, mode2 -1.
  - x=6 -> mode0 1, mode1 1, mode2 2.
  - x=2047 in mode2 -> data_out 511 and sat_flag set.
  - x=-2048 in mode2 -> -512 with no saturation.
- Flush at cycle 50 of FILL -> data_valid stays 0 and state returns to IDLE. A following new_symbol at cycle 60 -> valid at cycle 204. Flush also clears sat_flag.
- Invalid window: filter_in=0x3FC on both channels while data_valid=0 -> data_out=0 and sat_flag unchanged.
- Reset mid-RUN (reset asserted at cycle 300) -> data_out, data_valid, coeff_read_out and sat_flag all 0 immediately. After release, IDLE persists until the next new_symbol.
